// File: rtl/kulisch_avg_accumulator.sv
// Kulisch-style fixed-point group accumulator feeding an averaging divider.
// Sums a group of beats, counts them and flags inf/overflow/count saturation.
module kulisch_avg_accumulator #(
  parameter int ACC_NON_FRAC = 13,
  parameter int ACC_FRAC     = 24,
  parameter int DIV          = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             inValid,
  input  logic [ACC_NON_FRAC+ACC_FRAC-1:0] inData,
  input  logic                             inIsInf,
  input  logic                             inLast,
  output logic                             outValid,
  output logic                             outIsInf,
  output logic                             outIsOverflow,
  output logic                             outOverflowSign,
  output logic [ACC_NON_FRAC-1:0]          outNonFrac,
  output logic [ACC_FRAC-1:0]              outFrac,
  output logic [DIV-1:0]                   outDiv,
  output logic                             outCountSat
);

  localparam int W = ACC_NON_FRAC + ACC_FRAC;
  localparam logic [DIV-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]   sum_q, sum_d;
  logic [DIV-1:0] count_q, count_d;
  logic           inf_q, inf_d;
  logic           ovf_q, ovf_d;
  logic           ovf_sign_q, ovf_sign_d;
  logic           sat_q, sat_d;
  logic           load;

  logic [W-1:0]   add_val;
  logic [W-1:0]   sum_add;
  logic           step_ovf;
  logic           cnt_full;

  logic           out_valid_q;
  logic           out_inf_q;
  logic           out_ovf_q;
  logic           out_ovf_sign_q;
  logic [W-1:0]   out_sum_q;
  logic [DIV-1:0] out_div_q;
  logic           out_sat_q;

  // Next running state and FSM transition for the current beat.
  always_comb begin
    add_val    = inIsInf ? '0 : inData;
    sum_add    = sum_q + add_val;
    step_ovf   = !inIsInf
               && (sum_q[W-1] == inData[W-1])
               && (sum_add[W-1] != sum_q[W-1]);
    cnt_full   = (count_q == CNT_MAX);
    sum_d      = sum_q;
    count_d    = count_q;
    inf_d      = inf_q;
    ovf_d      = ovf_q;
    ovf_sign_d = ovf_sign_q;
    sat_d      = sat_q;
    state_d    = state_q;
    load       = 1'b0;
    if (inValid) begin
      sum_d   = sum_add;
      count_d = cnt_full ? count_q : count_q + DIV'(1);
      sat_d   = sat_q | cnt_full;
      inf_d   = inf_q | inIsInf;
      ovf_d   = ovf_q | step_ovf;
      if (step_ovf && !ovf_q) begin
        ovf_sign_d = inData[W-1];
      end
      load = inLast;
      unique case (state_q)
        IDLE:    state_d = inLast ? IDLE : ACCUM;
        ACCUM:   state_d = inLast ? IDLE : ACCUM;
        default: state_d = IDLE;
      endcase
    end
  end

  // Running state register; cleared on reset and when a group closes.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      count_q    <= '0;
      inf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_sign_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      inf_q      <= inf_d;
      ovf_q      <= ovf_d;
      ovf_sign_q <= ovf_sign_d;
      sat_q      <= sat_d;
    end
  end

  // Result register; loaded with the closing beat's totals, held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_inf_q      <= 1'b0;
      out_ovf_q      <= 1'b0;
      out_ovf_sign_q <= 1'b0;
      out_sum_q      <= '0;
      out_div_q      <= '0;
      out_sat_q      <= 1'b0;
    end else begin
      out_valid_q <= load;
      if (load) begin
        out_inf_q      <= inf_d;
        out_ovf_q      <= ovf_d;
        out_ovf_sign_q <= ovf_sign_d;
        out_sum_q      <= sum_d;
        out_div_q      <= count_d;
        out_sat_q      <= sat_d;
      end
    end
  end

  assign outValid        = out_valid_q;
  assign outIsInf        = out_inf_q;
  assign outIsOverflow   = out_ovf_q;
  assign outOverflowSign = out_ovf_sign_q;
  assign outNonFrac      = out_sum_q[W-1:ACC_FRAC];
  assign outFrac         = out_sum_q[ACC_FRAC-1:0];
  assign outDiv          = out_div_q;
  assign outCountSat     = out_sat_q;

endmodule

// File: tb/tb_kulisch_avg_accumulator.sv
// Scoreboard bench for kulisch_avg_accumulator.
// Expected group results are queued at the last beat and checked on outValid.
module tb_kulisch_avg_accumulator;

  localparam int NF = 13;
  localparam int FR = 24;
  localparam int DV = 8;
  localparam int W  = NF + FR;
  localparam longint ONE = 64'd1 << FR;

  typedef struct {
    logic [NF-1:0] nf;
    logic [FR-1:0] fr;
    logic [DV-1:0] dv;
    logic          inf;
    logic          ovf;
    logic          osgn;
    logic          sat;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          inValid = 1'b0;
  logic [W-1:0]  inData = '0;
  logic          inIsInf = 1'b0;
  logic          inLast = 1'b0;
  logic          outValid;
  logic          outIsInf;
  logic          outIsOverflow;
  logic          outOverflowSign;
  logic [NF-1:0] outNonFrac;
  logic [FR-1:0] outFrac;
  logic [DV-1:0] outDiv;
  logic          outCountSat;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  kulisch_avg_accumulator #(
    .ACC_NON_FRAC(NF),
    .ACC_FRAC(FR),
    .DIV(DV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .inValid(inValid),
    .inData(inData),
    .inIsInf(inIsInf),
    .inLast(inLast),
    .outValid(outValid),
    .outIsInf(outIsInf),
    .outIsOverflow(outIsOverflow),
    .outOverflowSign(outOverflowSign),
    .outNonFrac(outNonFrac),
    .outFrac(outFrac),
    .outDiv(outDiv),
    .outCountSat(outCountSat)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input longint sum, input int dv,
                              input bit inf, input bit ovf,
                              input bit osgn, input bit sat);
    exp_t e;
    logic [W-1:0] s;
    s     = sum[W-1:0];
    e.nf  = s[W-1:FR];
    e.fr  = s[FR-1:0];
    e.dv  = DV'(dv);
    e.inf = inf;
    e.ovf = ovf;
    e.osgn = osgn;
    e.sat = sat;
    return e;
  endfunction

  task automatic beat(input longint d, input bit inf, input bit last);
    inValid = 1'b1;
    inData  = d[W-1:0];
    inIsInf = inf;
    inLast  = last;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    inIsInf = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Compare each strobe against the oldest queued expectation.
  always @(negedge clock) begin
    if (outValid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(outValid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("nonfrac", 64'(outNonFrac), 64'(e.nf));
        chk("frac", 64'(outFrac), 64'(e.fr));
        chk("div", 64'(outDiv), 64'(e.dv));
        chk("inf", 64'(outIsInf), 64'(e.inf));
        chk("ovf", 64'(outIsOverflow), 64'(e.ovf));
        chk("ovf_sign", 64'(outOverflowSign), 64'(e.osgn));
        chk("cnt_sat", 64'(outCountSat), 64'(e.sat));
        chk("div_nonzero", 64'(outDiv != 0), 64'd1);
      end
    end
  end

  initial begin
    idle(3);
    @(negedge clock);
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_fields", 64'({outIsInf, outIsOverflow, outOverflowSign,
        outCountSat, outNonFrac, outFrac, outDiv}), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 5 + 4 + 2
    sb.push_back(mk(11 * ONE, 3, 0, 0, 0, 0));
    beat(5 * ONE, 0, 0);
    beat(4 * ONE, 0, 0);
    beat(2 * ONE, 0, 1);
    idle(3);
    @(negedge clock);
    chk("hold_valid", 64'(outValid), 64'd0);
    chk("hold_nonfrac", 64'(outNonFrac), 64'd11);
    chk("hold_div", 64'(outDiv), 64'd3);
    @(posedge clock);
    #1;

    // back-to-back single-beat groups
    sb.push_back(mk(ONE + ONE / 2, 1, 0, 0, 0, 0));
    beat(ONE + ONE / 2, 0, 1);
    sb.push_back(mk(2 * ONE + ONE / 4, 1, 0, 0, 0, 0));
    beat(2 * ONE + ONE / 4, 0, 1);
    idle(2);

    // gap inside group, negative result
    sb.push_back(mk(-(5 * ONE / 2), 2, 0, 0, 0, 0));
    beat(3 * ONE, 0, 0);
    idle(1);
    beat(-(11 * ONE / 2), 0, 1);
    idle(2);

    // positive overflow
    sb.push_back(mk((64'd1 << 36) - 1 + ONE, 2, 0, 1, 0, 0));
    beat((64'd1 << 36) - 1, 0, 0);
    beat(ONE, 0, 1);
    idle(2);

    // negative overflow first, then a positive one: sign stays negative
    sb.push_back(mk(64'd1 << 36, 3, 0, 1, 1, 0));
    beat(-(4096 * ONE), 0, 0);
    beat(-ONE, 0, 0);
    beat(ONE, 0, 1);
    idle(2);

    // inf beat counted but not summed
    sb.push_back(mk(8 * ONE, 3, 1, 0, 0, 0));
    beat(7 * ONE, 0, 0);
    beat(123 * ONE, 1, 0);
    beat(ONE, 0, 1);
    idle(2);

    // count saturation
    sb.push_back(mk(0, 255, 0, 0, 0, 1));
    for (int i = 0; i < 256; i++) beat(0, 0, i == 255);
    idle(2);

    // randomized small groups with gaps
    for (int g = 0; g < 6; g++) begin
      int n;
      longint acc;
      longint v;
      n = $urandom_range(1, 6);
      acc = 0;
      for (int i = 0; i < n; i++) begin
        v = longint'($urandom_range(0, 200 * 256)) - 100 * 256;
        v = v * (ONE / 256);
        acc += v;
        if (i == n - 1) sb.push_back(mk(acc, n, 0, 0, 0, 0));
        beat(v, 0, i == n - 1);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
    end
    idle(2);

    // reset mid-group discards partial state
    beat(9 * ONE, 0, 0);
    beat(3 * ONE, 0, 0);
    reset = 1'b1;
    inValid = 1'b1;
    inData = W'(ONE);
    inLast = 1'b1;
    @(negedge clock);
    chk("rst_mid_valid", 64'(outValid), 64'd0);
    @(posedge clock);
    #1;
    inValid = 1'b0;
    inLast = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rel_valid", 64'(outValid), 64'd0);
    @(posedge clock);
    #1;
    sb.push_back(mk(ONE, 1, 0, 0, 0, 0));
    beat(ONE, 0, 1);

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clock);
    idle(2);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
